// File: rtl/network_bf_in_xbar_pkg.sv
// Shared definitions for the butterfly input crossbar: defaults, select-width helper,
// slot index helpers and the route mode encoding.
package network_bf_in_xbar_pkg;

  localparam int unsigned DefDataWidth = 14;
  localparam int unsigned DefNLanes    = 8;

  typedef enum logic {
    ModeRoute    = 1'b0,
    ModeIdentity = 1'b1
  } xbar_mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

  // Butterfly k consumes slot 2k as u and slot 2k+1 as v.
  function automatic int unsigned u_slot(input int unsigned k);
    return 2 * k;
  endfunction

  function automatic int unsigned v_slot(input int unsigned k);
    return 2 * k + 1;
  endfunction

endpackage

// File: rtl/network_bf_in_xbar_if.sv
// Bank-read-side and BFU-side signals of the butterfly input crossbar.
interface network_bf_in_xbar_if
  import network_bf_in_xbar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned N_LANES    = DefNLanes
);

  localparam int unsigned SW = clog2(N_LANES);

  logic                          en;
  logic                          in_valid;
  logic                          identity_i;
  logic [N_LANES*SW-1:0]         sel_i;
  logic [N_LANES*DATA_WIDTH-1:0] q_i;
  logic                          clr_i;
  logic [N_LANES*DATA_WIDTH-1:0] out_o;
  logic                          out_valid_o;
  logic [N_LANES-1:0]            hit_o;
  logic                          conflict_o;
  logic                          conflict_sticky_o;

  modport master (
    output en, in_valid, identity_i, sel_i, q_i, clr_i,
    input  out_o, out_valid_o, hit_o, conflict_o, conflict_sticky_o
  );

  modport slave (
    input  en, in_valid, identity_i, sel_i, q_i, clr_i,
    output out_o, out_valid_o, hit_o, conflict_o, conflict_sticky_o
  );

endinterface

// File: rtl/network_bf_in_xbar_pipe_reg.sv
// Enable-gated shift register with asynchronous clear; aligns control with bank read data.
module network_bf_in_xbar_pipe_reg #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/network_bf_in_xbar.sv
// Butterfly input crossbar: routes bank read words to u/v operand slots using delayed
// per-source selects, with identity bypass, hold on unhit slots and conflict flags.
module network_bf_in_xbar
  import network_bf_in_xbar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned N_LANES    = DefNLanes,
  parameter int unsigned SEL_DELAY  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  network_bf_in_xbar_if.slave   bus
);

  localparam int unsigned SW = clog2(N_LANES);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = N_LANES * SW + 2;

  logic [PW-1:0]         pipe_q;
  logic                  valid_s;
  xbar_mode_e            mode_s;
  logic [N_LANES*SW-1:0] sel_s;

  network_bf_in_xbar_pipe_reg #(
    .W     (PW),
    .DEPTH (SEL_DELAY)
  ) u_sel_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .d     ({bus.in_valid, bus.identity_i, bus.sel_i}),
    .q     (pipe_q)
  );

  assign valid_s = pipe_q[PW-1];
  assign mode_s  = xbar_mode_e'(pipe_q[PW-2]);
  assign sel_s   = pipe_q[N_LANES*SW-1:0];

  logic [N_LANES*DW-1:0] route;
  logic [N_LANES-1:0]    hit;
  logic [N_LANES-1:0]    dup;

  for (genvar k = 0; k < N_LANES; k++) begin : g_slot
    logic [DW-1:0] win;
    logic          seen;
    logic          multi;

    // Ascending scan: the highest-numbered matching source is the one left in win.
    always_comb begin
      win   = bus.q_i[k*DW +: DW];
      seen  = 1'b0;
      multi = 1'b0;
      if (mode_s == ModeIdentity) begin
        seen = 1'b1;
      end else begin
        for (int j = 0; j < N_LANES; j++) begin
          if (sel_s[j*SW +: SW] == SW'(k)) begin
            multi = multi | seen;
            seen  = 1'b1;
            win   = bus.q_i[j*DW +: DW];
          end
        end
      end
    end

    assign route[k*DW +: DW] = win;
    assign hit[k]            = seen;
    assign dup[k]            = multi;
  end

  logic [N_LANES*DW-1:0] out_q, out_d;
  logic [N_LANES-1:0]    hit_q;
  logic                  valid_q, conflict_q, conflict_d, sticky_q, sticky_d;

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_LANES; k++) begin
      if (hit[k]) begin
        out_d[k*DW +: DW] = route[k*DW +: DW];
      end
    end
    conflict_d = valid_s & (|dup);
    sticky_d   = conflict_d | (sticky_q & ~bus.clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      hit_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else if (bus.en) begin
      if (valid_s) begin
        out_q <= out_d;
        hit_q <= hit;
      end
      valid_q    <= valid_s;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.out_o             = out_q;
  assign bus.hit_o             = hit_q;
  assign bus.out_valid_o       = valid_q;
  assign bus.conflict_o        = conflict_q;
  assign bus.conflict_sticky_o = sticky_q;

endmodule

// File: tb/tb_network_bf_in_xbar.sv
// Randomized self-checking bench for network_bf_in_xbar: default build (8 lanes, delay 1)
// plus a 4-lane, delay-3, 23-bit build, both against a slot-level reference model.
module tb_network_bf_in_xbar;

  localparam int NA = 8, SDA = 1, DWA = 14, SWA = 3;
  localparam int NB = 4, SDB = 3, DWB = 23, SWB = 2;

  typedef struct packed {
    logic             v;
    logic             id;
    logic [7:0][4:0]  sel;
    logic [7:0][31:0] q;
  } beat_t;

  logic clk;
  logic rst_n;

  network_bf_in_xbar_if #(.DATA_WIDTH(DWA), .N_LANES(NA)) ifa ();
  network_bf_in_xbar_if #(.DATA_WIDTH(DWB), .N_LANES(NB)) ifb ();

  network_bf_in_xbar #(
    .DATA_WIDTH (DWA),
    .N_LANES    (NA),
    .SEL_DELAY  (SDA)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  network_bf_in_xbar #(
    .DATA_WIDTH (DWB),
    .N_LANES    (NB),
    .SEL_DELAY  (SDB)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = 0;
  int cur_n = NA, cur_sd = SDA, cur_dw = DWA;

  // Reference state: what the BFU side should see for the instance under test.
  beat_t            pq[$];
  logic [7:0][31:0] m_out;
  logic [7:0]       m_hit;
  bit               m_valid, m_conf, m_sticky;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (inst %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  function automatic logic [31:0] dmask(input int dw);
    return (32'h1 << dw) - 32'h1;
  endfunction

  // mode 0: permutation, 1: random selects (duplicates likely), 2: identity
  function automatic beat_t rand_beat(input int n, input int mode, input int dw);
    beat_t b;
    int    perm[8];
    int    r, t;
    b    = '0;
    b.v  = 1'b1;
    b.id = (mode == 2);
    for (int j = 0; j < 8; j++) perm[j] = j;
    for (int j = n - 1; j > 0; j--) begin
      r = $urandom_range(j, 0);
      t = perm[j]; perm[j] = perm[r]; perm[r] = t;
    end
    for (int j = 0; j < n; j++) begin
      b.sel[j] = (mode == 0) ? 5'(perm[j]) : 5'($urandom_range(n - 1, 0));
      b.q[j]   = $urandom & dmask(dw);
    end
    return b;
  endfunction

  // Slot k takes the word of the last source (by index) that names it; identity maps k to k.
  task automatic model_step(input beat_t b, output bit conf);
    int w, cnt;
    conf = 0;
    for (int k = 0; k < cur_n; k++) begin
      w = -1;
      cnt = 0;
      for (int j = 0; j < cur_n; j++) begin
        if (int'(b.sel[j]) == k) begin
          w = j;
          cnt++;
        end
      end
      if (b.id) begin
        w = k;
        cnt = 1;
      end
      m_hit[k] = (w >= 0);
      if (w >= 0) m_out[k] = b.q[w];
      if (cnt > 1) conf = 1;
    end
  endtask

  task automatic drive(input bit en, input bit clr, input beat_t c, input beat_t qb);
    if (cur == 0) begin
      ifa.en = en; ifa.in_valid = c.v; ifa.identity_i = c.id; ifa.clr_i = clr;
      for (int j = 0; j < NA; j++) begin
        ifa.sel_i[j*SWA +: SWA] = c.sel[j][SWA-1:0];
        ifa.q_i[j*DWA +: DWA]   = qb.q[j][DWA-1:0];
      end
    end else begin
      ifb.en = en; ifb.in_valid = c.v; ifb.identity_i = c.id; ifb.clr_i = clr;
      for (int j = 0; j < NB; j++) begin
        ifb.sel_i[j*SWB +: SWB] = c.sel[j][SWB-1:0];
        ifb.q_i[j*DWB +: DWB]   = qb.q[j][DWB-1:0];
      end
    end
  endtask

  task automatic check_all();
    logic [255:0] exp_out;
    exp_out = '0;
    for (int k = 0; k < cur_n; k++) begin
      exp_out |= 256'(m_out[k] & dmask(cur_dw)) << (k * cur_dw);
    end
    if (cur == 0) begin
      check_eq("out", 256'(ifa.out_o), exp_out);
      check_eq("hit", 256'(ifa.hit_o), 256'(m_hit));
      check_eq("out_valid", 256'(ifa.out_valid_o), 256'(m_valid));
      check_eq("conflict", 256'(ifa.conflict_o), 256'(m_conf));
      check_eq("sticky", 256'(ifa.conflict_sticky_o), 256'(m_sticky));
    end else begin
      check_eq("out", 256'(ifb.out_o), exp_out);
      check_eq("hit", 256'(ifb.hit_o), 256'(m_hit));
      check_eq("out_valid", 256'(ifb.out_valid_o), 256'(m_valid));
      check_eq("conflict", 256'(ifb.conflict_o), 256'(m_conf));
      check_eq("sticky", 256'(ifb.conflict_sticky_o), 256'(m_sticky));
    end
  endtask

  // One clock: new control enters, bank data of the beat issued cur_sd enabled cycles ago
  // arrives. While stalled, inputs carry garbage that must not be sampled.
  task automatic run_cycle(input bit en, input bit clr, input beat_t nb);
    beat_t cb, qb;
    bit    have, c;
    have = 0;
    c    = 0;
    cb   = nb;
    qb   = rand_beat(cur_n, 1, cur_dw);
    if (en) begin
      pq.push_back(nb);
      if (pq.size() > cur_sd) begin
        qb   = pq.pop_front();
        have = 1;
      end
    end else begin
      cb   = rand_beat(cur_n, 1, cur_dw);
      cb.v = $urandom_range(1, 0);
    end
    drive(en, clr, cb, qb);
    @(posedge clk);
    if (en) begin
      if (have && qb.v) model_step(qb, c);
      m_valid  = have && qb.v;
      m_conf   = c;
      m_sticky = c | (m_sticky & ~clr);
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0;
    pq.delete();
    m_out = '0; m_hit = '0; m_valid = 0; m_conf = 0; m_sticky = 0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  beat_t idle, b;

  initial begin
    clk = 0;
    rst_n = 0;
    idle = '0;
    ifa.en = 0; ifa.in_valid = 0; ifa.identity_i = 0; ifa.sel_i = '0; ifa.q_i = '0; ifa.clr_i = 0;
    ifb.en = 0; ifb.in_valid = 0; ifb.identity_i = 0; ifb.sel_i = '0; ifb.q_i = '0; ifb.clr_i = 0;
    #2;

    // 8-lane build
    cur = 0; cur_n = NA; cur_sd = SDA; cur_dw = DWA;
    do_reset();

    // Reverse permutation
    b = '0; b.v = 1;
    for (int j = 0; j < 8; j++) begin b.sel[j] = 5'(7 - j); b.q[j] = 32'(100 + j); end
    run_cycle(1, 0, b);
    run_cycle(1, 0, idle);
    check_eq("rev_slot0", 256'(ifa.out_o[0 +: DWA]), 256'(107));
    check_eq("rev_slot7", 256'(ifa.out_o[7*DWA +: DWA]), 256'(100));
    check_eq("rev_hit", 256'(ifa.hit_o), 256'(8'hFF));

    // Sources 2 and 5 both target slot 3; slot 6 is left unhit and must keep 101
    b = '0; b.v = 1;
    b.sel[0] = 0; b.sel[1] = 1; b.sel[2] = 3; b.sel[3] = 2;
    b.sel[4] = 4; b.sel[5] = 3; b.sel[6] = 5; b.sel[7] = 7;
    for (int j = 0; j < 8; j++) b.q[j] = 32'(200 + j);
    run_cycle(1, 0, b);
    run_cycle(1, 0, idle);
    check_eq("cfl_slot3", 256'(ifa.out_o[3*DWA +: DWA]), 256'(205));
    check_eq("cfl_slot6", 256'(ifa.out_o[6*DWA +: DWA]), 256'(101));
    check_eq("cfl_flag", 256'(ifa.conflict_o), 256'(1));
    run_cycle(1, 1, idle);
    check_eq("clr_alone", 256'(ifa.conflict_sticky_o), 256'(0));
    run_cycle(1, 0, b);
    run_cycle(1, 1, idle);
    check_eq("clr_vs_set", 256'(ifa.conflict_sticky_o), 256'(1));

    // Identity toggling back to back
    for (int i = 0; i < 20; i++) run_cycle(1, 0, rand_beat(NA, (i % 2) ? 2 : 0, DWA));
    for (int i = 0; i < SDA; i++) run_cycle(1, 0, idle);

    // Stall of 3 cycles inside a 5-beat burst
    for (int i = 0; i < 2; i++) run_cycle(1, 0, rand_beat(NA, 0, DWA));
    for (int i = 0; i < 3; i++) run_cycle(0, 0, idle);
    for (int i = 0; i < 3; i++) run_cycle(1, 0, rand_beat(NA, 0, DWA));
    for (int i = 0; i < SDA + 1; i++) run_cycle(1, 0, idle);

    // Reset with beats in flight, then a fresh beat two cycles later
    for (int i = 0; i < 4; i++) run_cycle(1, 0, rand_beat(NA, 1, DWA));
    do_reset();
    run_cycle(1, 0, idle);
    run_cycle(1, 0, idle);
    run_cycle(1, 0, rand_beat(NA, 0, DWA));
    for (int i = 0; i < SDA + 1; i++) run_cycle(1, 0, idle);

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      b   = rand_beat(NA, $urandom_range(2, 0), DWA);
      b.v = ($urandom_range(4, 0) != 0);
      run_cycle($urandom_range(9, 0) != 0, $urandom_range(7, 0) == 0, b);
    end

    // 4-lane, delay-3, 23-bit build
    ifa.en = 0;
    cur = 1; cur_n = NB; cur_sd = SDB; cur_dw = DWB;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      run_cycle($urandom_range(19, 0) != 0, $urandom_range(15, 0) == 0, rand_beat(NB, 0, DWB));
    end
    for (int i = 0; i < SDB + 1; i++) run_cycle(1, 0, idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
